fifo_uart_tx: RTL and testbench

Downstream drain stage for the `fifo` block. It pops words from the FIFO read port and serialises each word onto a single asynchronous UART line: start bit, n data bits LSB first, optional parity, then stop bits. The block owns the FIFO read strobe (`clk_o`) and runs frames back-to-back while the FIFO is non-empty. It sits between the FIFO and the TX pin.

---
 rtl/fifo_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a FIFO onto an asynchronous UART line. A word is captured from
//   the FIFO head whenever the FIFO is non-empty and the transmitter is idle
//   (or is just finishing a frame). The word is then sent as a start bit,
//   n data bits LSB first, an optional parity bit and sb stop bits. Frames
//   run back-to-back with no idle gap while the FIFO has data.
//
// Parameters
//   n    word width (5..9)
//   div  clk cycles per UART bit (>= 2)
//   par  0 = no parity, 1 = even, 2 = odd
//   sb   stop bits (1 or 2)
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   data   in   FIFO head word, valid while empty = 0
//   empty  in   FIFO empty flag
//   clk_o  out  FIFO read strobe, one cycle high per captured word
//   tx     out  serial line, idle high
//   busy   out  high from word capture until the last stop bit ends
module fifo_uart_tx #(
    parameter int n   = 8,
    parameter int div = 104,
    parameter int par = 0,
    parameter int sb  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] data,
    input  logic         empty,
    output logic         clk_o,
    output logic         tx,
    output logic         busy
);

    localparam int CW = (div > 1) ? $clog2(div) : 1;
    localparam int BW = $clog2(n + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(div - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(n - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(sb - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [BW-1:0]  bi_q,    bi_d;
    logic [n-1:0]   shift_q, shift_d;
    logic           par_q,   par_d;
    logic           tx_q,    tx_d;
    logic           busy_q,  busy_d;
    logic           clk_o_q, clk_o_d;

    logic           bit_end;
    logic           capture;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bi_d    = bi_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        clk_o_d = 1'b0;

        bit_end = (cnt_q == CNT_LAST);
        // empty is only looked at while idle or on the very last stop cycle,
        // so the FIFO flag has settled long after the previous pop.
        capture = !empty &&
                  ((state_q == IDLE) ||
                   ((state_q == STOP) && bit_end && (bi_q == STOP_LAST)));

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bi_d    = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bi_q == DATA_LAST) begin
                        bi_d = '0;
                        if (par != 0) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Next bit to appear is the one about to land in shift[0].
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bi_d    = bi_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bi_d    = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bi_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                        bi_d    = '0;
                    end else begin
                        bi_d = bi_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Capture overrides the STOP-end transition so the next start bit
        // follows the last stop cycle directly.
        if (capture) begin
            shift_d = data;
            par_d   = (par == 2) ? ~^data : ^data;
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            clk_o_d = 1'b1;
            cnt_d   = '0;
            bi_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bi_q    <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            clk_o_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            clk_o_q <= clk_o_d;
        end
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign clk_o = clk_o_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances (no parity, even, odd, two stop
// bits) each fed from its own behavioural FIFO. A frame-level model turns
// every consumed word into the expected per-cycle tx waveform and compares
// tx, busy and clk_o on every falling clock edge.
module tb_fifo_uart_tx;

    localparam int N   = 8;
    localparam int DIV = 4;
    localparam int NI  = 4;

    logic clk;
    logic rst_n;

    logic [N-1:0] data_a  [NI];
    logic         empty_a [NI];
    logic         clk_o_a [NI];
    logic         tx_a    [NI];
    logic         busy_a  [NI];

    logic [N-1:0] fmem [NI][64];
    int unsigned  wp     [NI];
    int unsigned  pulses [NI];

    int total;
    int bad;
    bit chk_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int PG  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int SBG = (g == 3) ? 2 : 1;

        int unsigned rp;
        int unsigned mrp;
        bit          exp_q[$];
        bit          exp_pulse;
        logic [N-1:0] w;

        fifo_uart_tx #(
            .n   (N),
            .div (DIV),
            .par (PG),
            .sb  (SBG)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .data  (data_a[g]),
            .empty (empty_a[g]),
            .clk_o (clk_o_a[g]),
            .tx    (tx_a[g]),
            .busy  (busy_a[g])
        );

        // Behavioural FIFO: pops on the rising edge of the read strobe.
        initial rp = 0;
        always @(posedge clk_o_a[g]) begin
            rp++;
            pulses[g]++;
        end
        assign empty_a[g] = (wp[g] == rp);
        assign data_a[g]  = fmem[g][rp % 64];

        // Frame model: one queue entry per expected cycle of the frame.
        initial mrp = 0;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                exp_q.delete();
                exp_pulse = 1'b0;
            end else begin
                exp_pulse = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_q.size() == 0 && wp[g] != mrp) begin
                    w = fmem[g][mrp % 64];
                    mrp++;
                    exp_pulse = 1'b1;
                    for (int c = 0; c < DIV; c++) exp_q.push_back(1'b0);
                    for (int b = 0; b < N; b++)
                        for (int c = 0; c < DIV; c++) exp_q.push_back(w[b]);
                    if (PG != 0)
                        for (int c = 0; c < DIV; c++)
                            exp_q.push_back((PG == 1) ? (^w) : ~(^w));
                    for (int c = 0; c < SBG * DIV; c++) exp_q.push_back(1'b1);
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("tx%0d", g),    32'(tx_a[g]),    32'((exp_q.size() > 0) ? exp_q[0] : 1'b1));
                check($sformatf("busy%0d", g),  32'(busy_a[g]),  32'(exp_q.size() > 0));
                check($sformatf("clk_o%0d", g), 32'(clk_o_a[g]), 32'(exp_pulse));
            end
        end
    end

    task automatic push(input int i, input logic [N-1:0] v);
        fmem[i][wp[i] % 64] = v;
        wp[i]++;
    endtask

    task automatic drain(input int budget);
        int k;
        bit idle;
        k = 0;
        idle = 1'b0;
        while (!idle && k < budget) begin
            @(negedge clk);
            k++;
            idle = 1'b1;
            for (int i = 0; i < NI; i++)
                if (busy_a[i] || !empty_a[i]) idle = 1'b0;
        end
        // One extra cycle so a final busy fall is observed by the model.
        @(negedge clk);
        check("drain_done", 32'(idle), 32'd1);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            wp[i]     = 0;
            pulses[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_tx%0d", i),    32'(tx_a[i]),    32'd1);
            check($sformatf("rst_busy%0d", i),  32'(busy_a[i]),  32'd0);
            check($sformatf("rst_clk_o%0d", i), 32'(clk_o_a[i]), 32'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Empty hold
        repeat (200) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("hold_pulses%0d", i), pulses[i], 32'd0);

        // Single words: plain A5, parity on 07, two stop bits on 81
        push(0, 8'hA5);
        push(1, 8'h07);
        push(2, 8'h07);
        push(3, 8'h81);
        drain(200);

        // Back-to-back burst
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        drain(400);
        check("b2b_empty", 32'(empty_a[0]), 32'd1);
        check("b2b_pulses", pulses[0], 32'd4);

        // Reset during data bit 3 of 5A
        for (int i = 0; i < NI; i++) push(i, 8'h5A);
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("arst_tx%0d", i),    32'(tx_a[i]),    32'd1);
            check($sformatf("arst_busy%0d", i),  32'(busy_a[i]),  32'd0);
            check($sformatf("arst_clk_o%0d", i), 32'(clk_o_a[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) push(i, 8'hC3);
        drain(400);

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NI; i++)
                if ($urandom_range(0, 2) == 0) push(i, 8'($urandom));
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        drain(4000);

        for (int i = 0; i < NI; i++)
            check($sformatf("pulse_count%0d", i), pulses[i], wp[i]);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
